// File: rtl/vreg_wb_queue.sv
// In-order writeback queue feeding the vector register file write ports.
// Ports: CLK/RST, in_valid/in_ready/in_vd/in_vdata (enqueue side),
// wr_stall, wen/wvd/wvdata (registered write ports), count, empty.
module vreg_wb_queue #(
  parameter int DEPTH       = 8,
  parameter int WRITE_PORTS = 4,
  parameter int VIDX_W      = 8,
  parameter int VREG_W      = 512,
  parameter int BANK_IDX    = 2
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [VIDX_W-1:0]                      in_vd,
  input  logic [VREG_W-1:0]                      in_vdata,
  input  logic                                   wr_stall,
  output logic [WRITE_PORTS-1:0]                 wen,
  output logic [WRITE_PORTS-1:0][VIDX_W-1:0]     wvd,
  output logic [WRITE_PORTS-1:0][VREG_W-1:0]     wvdata,
  output logic [$clog2(DEPTH):0]                 count,
  output logic                                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SEL_W = $clog2(WRITE_PORTS + 1);
  localparam int NBANK = 1 << BANK_IDX;

  logic [VIDX_W-1:0] q_vd   [DEPTH];
  logic [VREG_W-1:0] q_data [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;

  logic                              enq;
  logic [SEL_W-1:0]                  n_sel;
  logic [SEL_W-1:0]                  pop;
  logic [WRITE_PORTS-1:0]            fire;
  logic [WRITE_PORTS-1:0][VIDX_W-1:0] sel_vd;
  logic [WRITE_PORTS-1:0][VREG_W-1:0] sel_data;

  logic [NBANK-1:0]    used;
  logic                stop;
  logic [PTR_W-1:0]    idx;
  logic [BANK_IDX-1:0] bnk;

  assign in_ready = !RST && (cnt < CNT_W'(DEPTH));
  assign enq      = in_valid && in_ready;
  assign pop      = wr_stall ? '0 : n_sel;
  assign count    = cnt;
  assign empty    = (cnt == '0);

  // Oldest-first walk; the first bank clash ends the group so
  // younger entries never overtake an older blocked one.
  always_comb begin
    n_sel    = '0;
    stop     = 1'b0;
    used     = '0;
    idx      = '0;
    bnk      = '0;
    sel_vd   = '0;
    sel_data = '0;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      idx         = head + PTR_W'(i);
      sel_vd[i]   = q_vd[idx];
      sel_data[i] = q_data[idx];
      bnk         = q_vd[idx][BANK_IDX-1:0];
      if (!stop && (CNT_W'(i) < cnt) && !used[bnk]) begin
        used[bnk] = 1'b1;
        n_sel     = n_sel + SEL_W'(1);
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    fire = '0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      fire[p] = SEL_W'(p) < pop;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      q_vd[tail]   <= in_vd;
      q_data[tail] <= in_vdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      wen    <= '0;
      wvd    <= '0;
      wvdata <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_W'(1);
      end
      head <= head + PTR_W'(pop);
      cnt  <= cnt + CNT_W'(enq) - CNT_W'(pop);
      for (int p = 0; p < WRITE_PORTS; p++) begin
        wen[p]    <= fire[p];
        wvd[p]    <= fire[p] ? sel_vd[p] : '0;
        wvdata[p] <= fire[p] ? sel_data[p] : '0;
      end
    end
  end

endmodule

// File: tb/tb_vreg_wb_queue.sv
// Directed bench for vreg_wb_queue: vector table plus
// reset-mid-drain and full/wrap-around sequences.
module tb_vreg_wb_queue;

  logic                  CLK;
  logic                  RST;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_vd;
  logic [511:0]          in_vdata;
  logic                  wr_stall;
  logic [3:0]            wen;
  logic [3:0][7:0]       wvd;
  logic [3:0][511:0]     wvdata;
  logic [3:0]            count;
  logic                  empty;

  int checks = 0;
  int errors = 0;

  vreg_wb_queue dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vd    (in_vd),
    .in_vdata (in_vdata),
    .wr_stall (wr_stall),
    .wen      (wen),
    .wvd      (wvd),
    .wvdata   (wvdata),
    .count    (count),
    .empty    (empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [7:0]  vd;
    logic        st;
    logic [3:0]  ewen;
    logic [31:0] evd;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] sb[$];

  function automatic logic [511:0] dat(input logic [7:0] v);
    if (v == 8'h08 || v == 8'h0A) return '1;
    if (v == 8'h09 || v == 8'h0B) return '0;
    return {64{v}};
  endfunction

  function automatic vec_t mk(input logic v, input logic [7:0] vd,
                              input logic st, input logic [3:0] ew,
                              input logic [31:0] evd,
                              input logic [3:0] ec);
    vec_t r;
    r.v = v; r.vd = vd; r.st = st;
    r.ewen = ew; r.evd = evd; r.ecnt = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  int nwr;

  task automatic drain_check;
    logic gap;
    logic [7:0] e;
    gap = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (wen[p]) begin
        chk("wen_prefix", {511'd0, gap}, 512'd0);
        if (sb.size() == 0) begin
          chk("extra_write", {504'd0, wvd[p]}, 512'd0);
        end else begin
          e = sb.pop_front();
          chk("wrap_vd", {504'd0, wvd[p]}, {504'd0, e});
          chk("wrap_data", wvdata[p], dat(e));
          nwr++;
        end
      end else begin
        gap = 1'b1;
      end
    end
  endtask

  initial begin
    int acc;
    RST      = 1'b1;
    in_valid = 1'b0;
    in_vd    = '0;
    in_vdata = '0;
    wr_stall = 1'b0;

    tick();
    chk("rst_wen", {508'd0, wen}, 512'd0);
    chk("rst_cnt", {508'd0, count}, 512'd0);
    chk("rst_empty", {511'd0, empty}, 512'd1);
    chk("rst_rdy", {511'd0, in_ready}, 512'd0);
    RST = 1'b0;
    #1;
    chk("rel_rdy", {511'd0, in_ready}, 512'd1);

    // no-conflict burst
    tbl.push_back(mk(1, 8'h08, 1, 4'b0000, 32'h0, 4'd1));
    tbl.push_back(mk(1, 8'h09, 1, 4'b0000, 32'h0, 4'd2));
    tbl.push_back(mk(1, 8'h0A, 1, 4'b0000, 32'h0, 4'd3));
    tbl.push_back(mk(1, 8'h0B, 1, 4'b0000, 32'h0, 4'd4));
    tbl.push_back(mk(0, 8'h00, 0, 4'b1111, 32'h0B0A0908, 4'd0));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 32'h0, 4'd0));
    // same-bank serialization
    tbl.push_back(mk(1, 8'h00, 1, 4'b0000, 32'h0, 4'd1));
    tbl.push_back(mk(1, 8'h04, 1, 4'b0000, 32'h0, 4'd2));
    tbl.push_back(mk(1, 8'h08, 1, 4'b0000, 32'h0, 4'd3));
    tbl.push_back(mk(1, 8'h0C, 1, 4'b0000, 32'h0, 4'd4));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0001, 32'h00, 4'd3));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0001, 32'h04, 4'd2));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0001, 32'h08, 4'd1));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0001, 32'h0C, 4'd0));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 32'h0, 4'd0));
    // order-preserving stop
    tbl.push_back(mk(1, 8'h01, 1, 4'b0000, 32'h0, 4'd1));
    tbl.push_back(mk(1, 8'h02, 1, 4'b0000, 32'h0, 4'd2));
    tbl.push_back(mk(1, 8'h05, 1, 4'b0000, 32'h0, 4'd3));
    tbl.push_back(mk(1, 8'h03, 1, 4'b0000, 32'h0, 4'd4));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0011, 32'h0201, 4'd2));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0011, 32'h0305, 4'd0));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 32'h0, 4'd0));
    // steady state, one per cycle
    tbl.push_back(mk(1, 8'h11, 0, 4'b0000, 32'h0, 4'd1));
    tbl.push_back(mk(1, 8'h12, 0, 4'b0001, 32'h11, 4'd1));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0001, 32'h12, 4'd0));
    // stall hold
    tbl.push_back(mk(1, 8'h21, 1, 4'b0000, 32'h0, 4'd1));
    tbl.push_back(mk(1, 8'h22, 1, 4'b0000, 32'h0, 4'd2));
    tbl.push_back(mk(0, 8'h00, 1, 4'b0000, 32'h0, 4'd2));
    tbl.push_back(mk(0, 8'h00, 1, 4'b0000, 32'h0, 4'd2));
    tbl.push_back(mk(0, 8'h00, 1, 4'b0000, 32'h0, 4'd2));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0011, 32'h2221, 4'd0));
    tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 32'h0, 4'd0));

    foreach (tbl[i]) begin
      in_valid = tbl[i].v;
      in_vd    = tbl[i].vd;
      in_vdata = dat(tbl[i].vd);
      wr_stall = tbl[i].st;
      tick();
      chk($sformatf("v%0d_wen", i), {508'd0, wen},
          {508'd0, tbl[i].ewen});
      chk($sformatf("v%0d_wvd", i), {480'd0, wvd},
          {480'd0, tbl[i].evd});
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("v%0d_data%0d", i, p), wvdata[p],
            tbl[i].ewen[p] ? dat(tbl[i].evd[p*8 +: 8]) : 512'd0);
      end
      chk($sformatf("v%0d_cnt", i), {508'd0, count},
          {508'd0, tbl[i].ecnt});
      chk($sformatf("v%0d_empty", i), {511'd0, empty},
          {511'd0, tbl[i].ecnt == 4'd0});
    end

    // reset mid-drain
    wr_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_vd    = 8'h31 + 8'(k);
      in_vdata = dat(in_vd);
      tick();
    end
    in_valid = 1'b0;
    wr_stall = 1'b0;
    tick();
    chk("mid_wen", {508'd0, wen}, {508'd0, 4'b1111});
    chk("mid_cnt", {508'd0, count}, 512'd1);
    #2 RST = 1'b1;
    #1;
    chk("arst_wen", {508'd0, wen}, 512'd0);
    chk("arst_wvd", {480'd0, wvd}, 512'd0);
    chk("arst_cnt", {508'd0, count}, 512'd0);
    chk("arst_empty", {511'd0, empty}, 512'd1);
    chk("arst_rdy", {511'd0, in_ready}, 512'd0);
    RST = 1'b0;
    #1;
    chk("arel_rdy", {511'd0, in_ready}, 512'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stale_wen", {508'd0, wen}, 512'd0);
      chk("stale_cnt", {508'd0, count}, 512'd0);
    end

    // full / backpressure / wrap-around
    acc = 0;
    nwr = 0;
    wr_stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_vd    = 8'h40 + 8'(acc);
      in_vdata = dat(in_vd);
      if (in_ready) begin
        sb.push_back(in_vd);
        acc++;
      end
      tick();
      chk("full_stall_wen", {508'd0, wen}, 512'd0);
    end
    chk("full_acc", 512'(acc), 512'd8);
    chk("full_cnt", {508'd0, count}, 512'd8);
    chk("full_rdy", {511'd0, in_ready}, 512'd0);
    wr_stall = 1'b0;
    for (int k = 0; k < 300 && nwr < 28; k++) begin
      in_valid = (acc < 28);
      in_vd    = 8'h40 + 8'(acc);
      in_vdata = dat(in_vd);
      if (in_valid && in_ready) begin
        sb.push_back(in_vd);
        acc++;
      end
      tick();
      drain_check();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_acc", 512'(acc), 512'd28);
    chk("wrap_nwr", 512'(nwr), 512'd28);
    chk("wrap_sb", 512'(sb.size()), 512'd0);
    chk("wrap_cnt", {508'd0, count}, 512'd0);
    chk("wrap_wen", {508'd0, wen}, 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
